// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit.
// MULDIV_MACC_EN adds the multiply-accumulate ops to the legal op set.
package muldiv_pkg;

    typedef enum logic [3:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        MTHI  = 4'd4,
        MTLO  = 4'd5,
        MADD  = 4'd6,
        MADDU = 4'd7,
        MSUB  = 4'd8,
        MSUBU = 4'd9
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        K_NONE,
        K_MUL,
        K_DIV,
        K_MTHI,
        K_MTLO
    } kind_e;

    function automatic kind_e op_kind(input logic [3:0] op);
        kind_e k;
        k = K_NONE;
        case (op)
            MULT, MULTU: k = K_MUL;
            DIV, DIVU:   k = K_DIV;
            MTHI:        k = K_MTHI;
            MTLO:        k = K_MTLO;
`ifdef MULDIV_MACC_EN
            MADD, MADDU, MSUB, MSUBU: k = K_MUL;
`endif
            default:     k = K_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
// E stage drives the master side; the unit implements the slave side.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, hi, lo
    );
endinterface

// File: rtl/muldiv_arith.sv
// Combinational product/quotient/remainder with MIPS corner-case rules.
// MULDIV_MACC_EN adds the {hi,lo} accumulate path.
module muldiv_arith
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MULDIV_MACC_EN
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
`endif
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic signed [W2-1:0]    prod_s;
    logic [W2-1:0]           prod_u;
    logic                    div_zero;
    logic                    div_ovf;
    logic [WIDTH-1:0]        bs_s;
    logic [WIDTH-1:0]        bs_u;
    logic signed [WIDTH-1:0] quo_s;
    logic signed [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0]        quo_u;
    logic [WIDTH-1:0]        rem_u;

    assign prod_s = $signed(a) * $signed(b);
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign div_zero = (b == '0);
    assign div_ovf  = (a == MIN_NEG) && (b == '1);

    // Corner cases are muxed in later; keep the dividers on safe divisors
    assign bs_s = (div_zero || div_ovf) ? ONE : b;
    assign bs_u = div_zero ? ONE : b;

    assign quo_s = $signed(a) / $signed(bs_s);
    assign rem_s = $signed(a) % $signed(bs_s);
    assign quo_u = a / bs_u;
    assign rem_u = a % bs_u;

`ifdef MULDIV_MACC_EN
    logic [W2-1:0] acc;
    assign acc = {hi, lo};
`endif

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MULT:  {res_hi, res_lo} = prod_s;
            MULTU: {res_hi, res_lo} = prod_u;
            DIV: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = '1;
                end else if (div_ovf) begin
                    res_hi = '0;
                    res_lo = a;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            DIVU: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = '1;
                end else begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
`ifdef MULDIV_MACC_EN
            MADD:  {res_hi, res_lo} = acc + $unsigned(prod_s);
            MADDU: {res_hi, res_lo} = acc + prod_u;
            MSUB:  {res_hi, res_lo} = acc - $unsigned(prod_s);
            MSUBU: {res_hi, res_lo} = acc - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// E-stage multiply/divide unit: HI/LO registers, latency FSM, cancel.
// Define MULDIV_MACC_EN to enable MADD/MADDU/MSUB/MSUBU.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic      clk,
    input  logic      reset,
    muldiv_if.slave   bus
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_e           state;
    state_e           state_nx;
    kind_e            kind;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic             hi_we;
    logic             lo_we;
    logic             pend_we;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             busy;

    muldiv_arith #(
        .WIDTH  (WIDTH)
    ) u_arith (
        .op     (bus.op),
        .a      (bus.a),
        .b      (bus.b),
`ifdef MULDIV_MACC_EN
        .hi     (hi_q),
        .lo     (lo_q),
`endif
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign kind = op_kind(bus.op);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start && (kind == K_MUL || kind == K_DIV))
                    state_nx = RUN;
            end
            RUN: begin
                if (bus.cancel || cnt == CNT_ONE)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == RUN);
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        hi_d    = pend_hi;
        lo_d    = pend_lo;
        pend_we = 1'b0;
        cnt_nx  = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    unique case (kind)
                        K_MTHI: begin
                            hi_we = 1'b1;
                            hi_d  = bus.a;
                        end
                        K_MTLO: begin
                            lo_we = 1'b1;
                            lo_d  = bus.a;
                        end
                        K_MUL: begin
                            pend_we = 1'b1;
                            cnt_nx  = MUL_CNT;
                        end
                        K_DIV: begin
                            pend_we = 1'b1;
                            cnt_nx  = DIV_CNT;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Cancel outranks a completion landing in the same cycle
                if (bus.cancel) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_ONE) begin
                    hi_we  = 1'b1;
                    lo_we  = 1'b1;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            default: cnt_nx = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            cnt <= cnt_nx;
            if (hi_we) hi_q <= hi_d;
            if (lo_we) lo_q <= lo_d;
            if (pend_we) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected HI/LO,
// monitor pops and compares when each op is due to retire.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(
        .WIDTH   (W),
        .MUL_LAT (ML),
        .DIV_LAT (DL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
        int           bcnt;
        string        name;
    } exp_t;

    exp_t         q[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: lat<0 no-op, lat=0 move, lat>0 multi-cycle
    function automatic void ref_op(input logic [3:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output int lat,
                                   output logic [W-1:0] nh,
                                   output logic [W-1:0] nl);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = -1;
        nh  = mhi;
        nl  = mlo;
        p   = '0;
        case (op)
            4'd0: begin p = sa * sb; {nh, nl} = p; lat = ML; end
            4'd1: begin
                p = {32'b0, a} * {32'b0, b};
                {nh, nl} = p;
                lat = ML;
            end
            4'd2: begin
                lat = DL;
                if (b == 0) begin nh = a; nl = '1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    begin nh = 0; nl = a; end
                else begin nl = W'(sa / sb); nh = W'(sa % sb); end
            end
            4'd3: begin
                lat = DL;
                if (b == 0) begin nh = a; nl = '1; end
                else begin nl = a / b; nh = a % b; end
            end
            4'd4: begin nh = a; lat = 0; end
            4'd5: begin nl = a; lat = 0; end
`ifdef MULDIV_MACC_EN
            4'd6: begin p = {mhi, mlo} + 64'(sa * sb); {nh, nl} = p; lat = ML; end
            4'd7: begin p = {mhi, mlo} + {32'b0, a} * {32'b0, b}; {nh, nl} = p; lat = ML; end
            4'd8: begin p = {mhi, mlo} - 64'(sa * sb); {nh, nl} = p; lat = ML; end
            4'd9: begin p = {mhi, mlo} - {32'b0, a} * {32'b0, b}; {nh, nl} = p; lat = ML; end
`endif
            default: lat = -1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // cancel_k>0: cancel in cycle t+k; cancel_k<0: cancel alongside start
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int cancel_k,
                          input bit intrude, input string name);
        int           lat;
        int           t;
        logic [W-1:0] nh;
        logic [W-1:0] nl;
        exp_t         e;
        ref_op(op, a, b, lat, nh, nl);
        t = cyc;
        e.name = name;
        if (lat > 0 && cancel_k > 0 && cancel_k <= lat) begin
            e.hi = mhi; e.lo = mlo;
            e.due = t + cancel_k + 1; e.bcnt = cancel_k;
        end else if (lat > 0) begin
            e.hi = nh; e.lo = nl;
            e.due = t + lat + 1; e.bcnt = lat;
            mhi = nh; mlo = nl;
        end else begin
            e.hi = nh; e.lo = nl;
            e.due = t + 1; e.bcnt = 0;
            mhi = nh; mlo = nl;
        end
        q.push_back(e);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.a      = a;
        bus.b      = b;
        bus.cancel = (cancel_k < 0);
        step();
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.a      = $urandom;
        bus.b      = $urandom;
        bus.op     = 4'($urandom);
        if (lat >= 3 && intrude && cancel_k <= 0) begin
            while (cyc < t + 3) step();
            bus.start = 1'b1;
            bus.op    = 4'd4;
            bus.a     = $urandom;
            step();
            bus.start = 1'b0;
        end
        if (lat > 0 && cancel_k > 0 && cancel_k <= lat) begin
            while (cyc < t + cancel_k) step();
            bus.cancel = 1'b1;
            step();
            bus.cancel = 1'b0;
        end
        while (cyc < e.due) step();
    endtask

    initial begin : monitor
        exp_t e;
        int   bc;
        bc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bc = 0;
            end else begin
                if (bus.busy) bc++;
                if (q.size() > 0 && cyc >= q[0].due) begin
                    e = q.pop_front();
                    chk({e.name, " hi"}, 64'(bus.hi), 64'(e.hi));
                    chk({e.name, " lo"}, 64'(bus.lo), 64'(e.lo));
                    chk({e.name, " busy_end"}, 64'(bus.busy), 64'd0);
                    chk({e.name, " busy_cycles"}, 64'(bc), 64'(e.bcnt));
                    bc = 0;
                end
            end
        end
    end

    initial begin : driver
        logic [3:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           ck;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = '0;
        bus.a      = '0;
        bus.b      = '0;
        #12;
        chk("reset hi", 64'(bus.hi), 64'd0);
        chk("reset lo", 64'(bus.lo), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        step();
        reset = 1'b0;
        step();

        run_op(4'd0, 32'hFFFF_FFFF, 32'd2, 0, 0, "mult");
        run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 0, 0, "multu");
        run_op(4'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, "div neg");
        run_op(4'd3, 32'd7, 32'd0, 0, 0, "divu by0");
        run_op(4'd2, 32'd9, 32'd0, 0, 0, "div by0");
        run_op(4'd4, 32'h1234_5678, 32'd0, 0, 0, "mthi");
        run_op(4'd5, 32'hCAFE_F00D, 32'd0, 0, 0, "mtlo");
        run_op(4'd2, 32'd100, 32'd7, 0, 1, "div intruded");
        run_op(4'd2, 32'd1000, 32'd3, 4, 0, "div cancel");
        run_op(4'd0, 32'd3, 32'd4, -1, 0, "mult cancel idle");
        run_op(4'd0, 32'd6, 32'd7, ML, 0, "mult cancel last");
        run_op(4'd15, 32'd1, 32'd1, 0, 0, "undef op");
        run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div ovf");
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "divu big");

        bus.start = 1'b1;
        bus.op    = 4'd0;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        step();
        bus.start = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst hi", 64'(bus.hi), 64'd0);
        chk("midrst lo", 64'(bus.lo), 64'd0);
        chk("midrst busy", 64'(bus.busy), 64'd0);
        q.delete();
        mhi = '0;
        mlo = '0;
        step();
        reset = 1'b0;
        step();
        run_op(4'd15, 32'd0, 32'd0, 0, 0, "post reset");

`ifdef MULDIV_MACC_EN
        run_op(4'd4, 32'd0, 32'd0, 0, 0, "macc mthi");
        run_op(4'd5, 32'd5, 32'd0, 0, 0, "macc mtlo");
        run_op(4'd6, 32'd3, 32'd4, 0, 0, "madd");
        run_op(4'd8, 32'd1, 32'h12, 0, 0, "msub");
`endif

        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) rb = '0;
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 9));
            if ($urandom_range(0, 15) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            ck = ($urandom_range(0, 6) == 0) ? $urandom_range(1, ML) : 0;
            if ($urandom_range(0, 9) == 0) ck = -1;
            run_op(rop, ra, rb, ck, ($urandom_range(0, 7) == 0),
                   "random");
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        chk("queue drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
